pipelined_multiplier: RTL and testbench

Fully pipelined multiply-add that computes signed multiplicand × unsigned multiplier + signed addend. It is the inverse datapath of the team's pipelined divider: feeding quotient, divisor and remainder back in reconstructs the dividend. It is used to check divider results and to rescale values on the same tagged, valid-qualified stream interface. It accepts one operation per cycle, has no backpressure, and emits results in order with their tag.

---
 rtl/pipelined_multiplier_if.sv | 35 +++
 rtl/pipelined_multiplier.sv | 135 +++++++++++++
 tb/tb_pipelined_multiplier.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_multiplier_if.sv
//------------------------------------------------------------------------------
// Module  : pipelined_multiplier_if
// Brief   : Tagged, valid-qualified operand/result stream for the multiply-add.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pipelined_multiplier_if #(
    parameter int MULTIPLICAND_WIDTH = 16,
    parameter int MULTIPLIER_WIDTH   = 8
);
    localparam int P         = MULTIPLICAND_WIDTH + MULTIPLIER_WIDTH;
    localparam int TAG_WIDTH = 6;

    logic                          input_valid;
    logic [TAG_WIDTH-1:0]          input_tag;
    logic [MULTIPLIER_WIDTH-1:0]   multiplier;
    logic [MULTIPLICAND_WIDTH-1:0] multiplicand;
    logic [MULTIPLICAND_WIDTH-1:0] addend;
    logic                          output_valid;
    logic [TAG_WIDTH-1:0]          output_tag;
    logic [P-1:0]                  product;

    modport master (
        output input_valid, input_tag, multiplier, multiplicand, addend,
        input  output_valid, output_tag, product
    );

    modport slave (
        input  input_valid, input_tag, multiplier, multiplicand, addend,
        output output_valid, output_tag, product
    );
endinterface

`default_nettype wire

// File: rtl/pipelined_multiplier.sv
//------------------------------------------------------------------------------
// Module  : pipelined_multiplier
// Brief   : Shift-add pipelined signed x unsigned multiply plus signed addend.
//           Optional occupancy counter: PIPELINED_MULTIPLIER_OCCUPANCY_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipelined_multiplier #(
    parameter int MULTIPLICAND_WIDTH = 16,
    parameter int MULTIPLIER_WIDTH   = 8
) (
    input  wire logic              clock,
    input  wire logic              reset,
    pipelined_multiplier_if.slave  bus
`ifdef PIPELINED_MULTIPLIER_OCCUPANCY_EN
    ,
    output logic [$clog2(MULTIPLIER_WIDTH+3)-1:0] in_flight
`endif
);
    localparam int W  = MULTIPLICAND_WIDTH;
    localparam int MW = MULTIPLIER_WIDTH;
    localparam int P  = W + MW;

    // Stage arrays: index 0 is the capture stage, MW is the last shift-add stage.
    logic          r_valid  [0:MW];
    logic [5:0]    r_tag    [0:MW];
    logic          r_neg    [0:MW];
    logic [P-1:0]  r_addend [0:MW];
    logic [P-1:0]  r_acc    [0:MW];
    logic [W:0]    r_mag    [0:MW-1];
    logic [MW-1:0] r_mult   [0:MW-1];

    logic          r_out_valid;
    logic [5:0]    r_out_tag;
    logic [P-1:0]  r_product;

    logic [W:0]    w_mc_ext;
    logic [W:0]    w_mag;
    logic [P-1:0]  w_addend_ext;
    logic [P-1:0]  w_signed_acc;

    // One extra bit so that the magnitude of the most negative value is exact.
    assign w_mc_ext     = {bus.multiplicand[W-1], bus.multiplicand};
    assign w_mag        = bus.multiplicand[W-1] ? -w_mc_ext : w_mc_ext;
    assign w_addend_ext = {{MW{bus.addend[W-1]}}, bus.addend};
    assign w_signed_acc = r_neg[MW] ? -r_acc[MW] : r_acc[MW];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid[0]  <= 1'b0;
            r_tag[0]    <= '0;
            r_neg[0]    <= 1'b0;
            r_addend[0] <= '0;
            r_acc[0]    <= '0;
            r_mag[0]    <= '0;
            r_mult[0]   <= '0;
        end else begin
            r_valid[0]  <= bus.input_valid;
            r_tag[0]    <= bus.input_tag;
            r_neg[0]    <= bus.multiplicand[W-1];
            r_addend[0] <= w_addend_ext;
            r_acc[0]    <= '0;
            r_mag[0]    <= w_mag;
            r_mult[0]   <= bus.multiplier;
        end
    end

    for (genvar i = 1; i <= MW; i++) begin : g_stage
        // Multiplier bits are consumed MSB first, so the accumulator doubles each stage.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_neg[i]    <= 1'b0;
                r_addend[i] <= '0;
                r_acc[i]    <= '0;
            end else begin
                r_valid[i]  <= r_valid[i-1];
                r_tag[i]    <= r_tag[i-1];
                r_neg[i]    <= r_neg[i-1];
                r_addend[i] <= r_addend[i-1];
                r_acc[i]    <= (r_acc[i-1] << 1)
                             + (r_mult[i-1][MW-i] ? P'(r_mag[i-1]) : '0);
            end
        end

        if (i < MW) begin : g_pass
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_mag[i]  <= '0;
                    r_mult[i] <= '0;
                end else begin
                    r_mag[i]  <= r_mag[i-1];
                    r_mult[i] <= r_mult[i-1];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_tag   <= '0;
            r_product   <= '0;
        end else begin
            r_out_valid <= r_valid[MW];
            r_out_tag   <= r_tag[MW];
            r_product   <= w_signed_acc + r_addend[MW];
        end
    end

    assign bus.output_valid = r_out_valid;
    assign bus.output_tag   = r_out_tag;
    assign bus.product      = r_product;

`ifdef PIPELINED_MULTIPLIER_OCCUPANCY_EN
    localparam int CNT_W = $clog2(MW + 3);

    logic [CNT_W-1:0] r_in_flight;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_in_flight <= '0;
        end else begin
            r_in_flight <= r_in_flight + CNT_W'(bus.input_valid) - CNT_W'(r_valid[MW]);
        end
    end

    assign in_flight = r_in_flight;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipelined_multiplier.sv
//------------------------------------------------------------------------------
// Module  : tb_pipelined_multiplier
// Brief   : Directed and random checks of pipelined_multiplier against an
//           arithmetic reference of issued operations.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipelined_multiplier;
    localparam int MCW = 16;
    localparam int MRW = 8;
    localparam int P   = MCW + MRW;
    localparam int LAT = 10;
    localparam int HN  = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipelined_multiplier_if #(.MULTIPLICAND_WIDTH(MCW), .MULTIPLIER_WIDTH(MRW)) bus ();

`ifdef PIPELINED_MULTIPLIER_OCCUPANCY_EN
    logic [3:0] in_flight;
`endif

    pipelined_multiplier #(.MULTIPLICAND_WIDTH(MCW), .MULTIPLIER_WIDTH(MRW)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
`ifdef PIPELINED_MULTIPLIER_OCCUPANCY_EN
        ,
        .in_flight (in_flight)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Operation history indexed by the cycle in which it was driven.
    logic         hv [HN];
    logic [5:0]   ht [HN];
    logic [P-1:0] hp [HN];

    function automatic logic [P-1:0] ref_mul(logic signed [MCW-1:0] mc, logic [MRW-1:0] mr,
                                             logic signed [MCW-1:0] ad);
        longint r;
        r = longint'(mc) * longint'(mr) + longint'(ad);
        return r[P-1:0];
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic verify();
        int  k;
        logic ev;
        if (rst) begin
            check("rst_valid", 32'(bus.output_valid), 32'd0);
            check("rst_tag", 32'(bus.output_tag), 32'd0);
            check("rst_product", 32'(bus.product), 32'd0);
`ifdef PIPELINED_MULTIPLIER_OCCUPANCY_EN
            check("rst_in_flight", 32'(in_flight), 32'd0);
`endif
        end else begin
            k  = cyc - LAT;
            ev = 1'b0;
            if (k >= 0) ev = hv[k];
            check("out_valid", 32'(bus.output_valid), 32'(ev));
            if (ev) begin
                check("out_tag", 32'(bus.output_tag), 32'(ht[k]));
                check("out_product", 32'(bus.product), 32'(hp[k]));
            end
`ifdef PIPELINED_MULTIPLIER_OCCUPANCY_EN
            begin
                int n;
                n = 0;
                for (int j = cyc - LAT + 1; j < cyc; j++)
                    if (j >= 0 && hv[j]) n++;
                check("in_flight", 32'(in_flight), 32'(n));
            end
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        verify();
    endtask

    task automatic issue(logic v, logic [5:0] tag, logic [MRW-1:0] mr,
                         logic [MCW-1:0] mc, logic [MCW-1:0] ad);
        bus.input_valid  = v;
        bus.input_tag    = tag;
        bus.multiplier   = mr;
        bus.multiplicand = mc;
        bus.addend       = ad;
        hv[cyc] = v;
        ht[cyc] = tag;
        hp[cyc] = ref_mul(mc, mr, ad);
        tick();
    endtask

    task automatic idle(int n);
        repeat (n) issue(1'b0, 6'($urandom), MRW'($urandom), MCW'($urandom), MCW'($urandom));
    endtask

    task automatic do_reset(int hold);
        rst = 1'b1;
        for (int j = cyc - LAT; j <= cyc; j++)
            if (j >= 0) hv[j] = 1'b0;
        bus.input_valid = 1'b0;
        repeat (hold) tick();
        rst = 1'b0;
    endtask

    initial begin
        for (int j = 0; j < HN; j++) begin
            hv[j] = 1'b0;
            ht[j] = '0;
            hp[j] = '0;
        end
        bus.input_valid  = 1'b0;
        bus.input_tag    = '0;
        bus.multiplier   = '0;
        bus.multiplicand = '0;
        bus.addend       = '0;

        // Power-on reset: outputs must read zero throughout.
        repeat (3) tick();
        rst = 1'b0;
        idle(2);

        // Single pulse, exact latency and value.
        issue(1'b1, 6'h2A, 8'd200, 16'd1234, 16'd5);
        idle(LAT - 1);
        check("t1_valid", 32'(bus.output_valid), 32'd1);
        check("t1_tag", 32'(bus.output_tag), 32'h2A);
        check("t1_product", 32'(bus.product), 32'h03C415);
        idle(2);

        // Range extremes.
        issue(1'b1, 6'd1, 8'd255, 16'h8000, 16'h8000);
        issue(1'b1, 6'd2, 8'd255, 16'h7FFF, 16'h7FFF);
        idle(LAT - 2);
        check("t2_min", 32'(bus.product), 32'h800000);
        idle(1);
        check("t2_max", 32'(bus.product), 32'h7FFF00);
        idle(2);

        // Zero multiplier and zero multiplicand.
        issue(1'b1, 6'd3, 8'd0, 16'hFFF9, 16'hFFFD);
        issue(1'b1, 6'd4, 8'd255, 16'd0, 16'd0);
        idle(LAT - 2);
        check("t3_zero_mr", 32'(bus.product), 32'hFFFFFD);
        idle(1);
        check("t3_zero_mc", 32'(bus.product), 32'h000000);
        idle(2);

        // Back-to-back random stream.
        for (int t = 0; t < 20; t++)
            issue(1'b1, 6'(t), MRW'($urandom), MCW'($urandom), MCW'($urandom));
        idle(LAT + 2);

        // Bubble pattern 1,0,1,1,0.
        issue(1'b1, 6'd30, MRW'($urandom), MCW'($urandom), MCW'($urandom));
        idle(1);
        issue(1'b1, 6'd31, MRW'($urandom), MCW'($urandom), MCW'($urandom));
        issue(1'b1, 6'd32, MRW'($urandom), MCW'($urandom), MCW'($urandom));
        idle(LAT + 2);

        // Reset mid-flight discards three operations.
        issue(1'b1, 6'd40, MRW'($urandom), MCW'($urandom), MCW'($urandom));
        issue(1'b1, 6'd41, MRW'($urandom), MCW'($urandom), MCW'($urandom));
        issue(1'b1, 6'd42, MRW'($urandom), MCW'($urandom), MCW'($urandom));
        idle(1);
`ifdef PIPELINED_MULTIPLIER_OCCUPANCY_EN
        check("t6_in_flight_pre", 32'(in_flight), 32'd3);
`endif
        do_reset(2);
        idle(LAT + 2);

        // Fresh operation after reset.
        issue(1'b1, 6'd50, 8'd3, 16'hFF9C, 16'd7);
        idle(LAT - 1);
        check("t6_fresh_valid", 32'(bus.output_valid), 32'd1);
        check("t6_fresh_tag", 32'(bus.output_tag), 32'd50);
        check("t6_fresh_product", 32'(bus.product), 32'hFFFEDB);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
